// File: rtl/muldiv_ctrl_if.sv
// EX-stage multiply/divide port bundle: issue side (start/funct/operands)
// and result side (read data, HI/LO, status).
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] dataOut;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, Signal, dataA, dataB,
        input  dataOut, busy, stall, done, hi, lo, div_zero
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output dataOut, busy, stall, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle unsigned MULTU/DIVU sequencer owning the HI/LO pair.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle;
// raises stall to the hazard logic while an operation is in flight.
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  bus
);
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_s;
    logic [WIDTH:0]   div_diff;
    logic             last_iter;
    logic             md_funct;

    // Carry out of the add lands in the HI MSB after the right shift.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    // Partial remainder shifted left by one, pulling in the next dividend bit.
    assign div_s     = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_s - {1'b0, dvsr_q};
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    assign md_funct = (bus.Signal == F_MULTU) || (bus.Signal == F_DIVU) ||
                      (bus.Signal == F_MFHI)  || (bus.Signal == F_MFLO) ||
                      (bus.Signal == F_MTHI)  || (bus.Signal == F_MTLO);

    assign bus.busy     = (state_q == MUL) || (state_q == DIV);
    assign bus.done     = (state_q == DONE);
    assign bus.stall    = bus.busy && bus.start && md_funct;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = dz_q;
    // Reads are not gated by start; while busy the value is partial but stalled.
    assign bus.dataOut  = (bus.Signal == F_MFHI) ? hi_q :
                          (bus.Signal == F_MFLO) ? lo_q : '0;

    // Next-state and datapath next-values for the sequencer.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.Signal)
                        F_MULTU: begin
                            mcand_d = bus.dataA;
                            hi_d    = '0;
                            lo_d    = bus.dataB;
                            cnt_d   = '0;
                            dz_d    = 1'b0;
                            state_d = MUL;
                        end
                        F_DIVU: begin
                            if (bus.dataB != '0) begin
                                dvsr_d  = bus.dataB;
                                hi_d    = '0;
                                lo_d    = bus.dataA;
                                cnt_d   = '0;
                                dz_d    = 1'b0;
                                state_d = DIV;
                            end else begin
                                // Divide by zero finishes immediately with a flagged result.
                                hi_d    = bus.dataA;
                                lo_d    = '1;
                                dz_d    = 1'b1;
                                state_d = DONE;
                            end
                        end
                        F_MTHI:  hi_d = bus.dataA;
                        F_MTLO:  lo_d = bus.dataA;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                hi_d  = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = DONE;
            end
            DIV: begin
                if (!div_diff[WIDTH]) begin
                    hi_d = div_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_s[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // HI/LO, operand latches, iteration counter and divide-by-zero flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected HI/LO/div_zero
// and done-cycle from an arithmetic model; a monitor pops on every done pulse.
module tb_muldiv_ctrl;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MTLO  = 6'b010011;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_ctrl_if #(.WIDTH(32)) mif();

    muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h @cyc %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: plain 64-bit product and integer quotient/remainder.
    task automatic push_exp(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        case (sig)
            MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32]; e.lo = p[31:0]; e.dz = 1'b0; e.cyc = cyc + 33;
                sb.push_back(e);
            end
            DIVU: begin
                if (b == 0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.cyc = cyc + 1;
                end else begin
                    e.hi = a % b; e.lo = a / b; e.dz = 1'b0; e.cyc = cyc + 33;
                end
                sb.push_back(e);
            end
            default: ;
        endcase
        if (sig == MULTU || sig == DIVU) begin
            m_hi = e.hi;
            m_lo = e.lo;
        end
        if (sig == MTHI) m_hi = a;
        if (sig == MTLO) m_lo = a;
    endtask

    // Drive one instruction for a single edge, then scramble the operands.
    task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mif.start = 1'b1; mif.Signal = sig; mif.dataA = a; mif.dataB = b;
        push_exp(sig, a, b);
        @(negedge clk);
        mif.start = 1'b0;
        mif.dataA = $urandom;
        mif.dataB = $urandom;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (mif.done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout @cyc %0d", cyc);
        end
    endtask

    task automatic readback();
        chk("hi_reg", mif.hi, m_hi);
        chk("lo_reg", mif.lo, m_lo);
        mif.Signal = MFHI; #1;
        chk("mfhi", mif.dataOut, m_hi);
        mif.Signal = MFLO; #1;
        chk("mflo", mif.dataOut, m_lo);
    endtask

    task automatic run_op(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        issue(sig, a, b);
        if (sig == MULTU || sig == DIVU) wait_done();
        readback();
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (reset && mif.done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done act=1 exp=0 @cyc %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_hi", mif.hi, e.hi);
                chk("sb_lo", mif.lo, e.lo);
                chk("sb_dz", 32'(mif.div_zero), 32'(e.dz));
                chk("sb_done_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        mif.start = 1'b0; mif.Signal = 6'd0; mif.dataA = '0; mif.dataB = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", mif.hi, 0);
        chk("rst_lo", mif.lo, 0);
        chk("rst_busy", 32'(mif.busy), 0);
        chk("rst_done", 32'(mif.done), 0);
        chk("rst_stall", 32'(mif.stall), 0);
        chk("rst_dz", 32'(mif.div_zero), 0);
        reset = 1'b1;

        issue(MULTU, 7, 6);
        chk("mul_busy", 32'(mif.busy), 1);
        wait_done();
        readback();
        chk("mflo_42", mif.dataOut, 42);

        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(DIVU, 100, 7);
        run_op(DIVU, 32'hFFFF_FFFF, 1);

        issue(DIVU, 5, 0);
        chk("dz_busy", 32'(mif.busy), 0);
        chk("dz_done", 32'(mif.done), 1);
        wait_done();
        readback();
        run_op(MULTU, 2, 3);
        chk("dz_cleared", 32'(mif.div_zero), 0);

        // Interlock: hold an MFLO (and one stray MULTU) against a busy unit.
        @(negedge clk);
        mif.start = 1'b1; mif.Signal = MULTU; mif.dataA = 3; mif.dataB = 4;
        push_exp(MULTU, 3, 4);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 5) begin
                mif.Signal = MULTU; mif.dataA = 9; mif.dataB = 9;
            end else begin
                mif.Signal = MFLO;
            end
            #1;
            chk("stall_busy", 32'(mif.stall), 1);
        end
        @(negedge clk);
        mif.Signal = MFLO; #1;
        chk("stall_released", 32'(mif.stall), 0);
        chk("done_read_mflo", mif.dataOut, 12);
        mif.start = 1'b0;
        readback();

        issue(MTHI, 32'h55, 0);
        chk("mthi", mif.hi, 32'h55);
        readback();

        // Reset in the middle of a divide discards it.
        issue(DIVU, 32'hDEAD_BEEF, 7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        m_hi = '0; m_lo = '0;
        chk("midrst_hi", mif.hi, 0);
        chk("midrst_lo", mif.lo, 0);
        chk("midrst_busy", 32'(mif.busy), 0);
        chk("midrst_done", 32'(mif.done), 0);
        reset = 1'b1;
        run_op(MULTU, 2, 2);

        for (int n = 0; n < 24; n++) begin
            int unsigned r;
            logic [31:0] a, b;
            r = $urandom_range(0, 5);
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300));
            case (r)
                0, 1: run_op(MULTU, a, b);
                2, 3: run_op(DIVU, a, b);
                4:    run_op(MTHI, a, b);
                default: run_op(MTLO, a, b);
            endcase
        end
        run_op(DIVU, $urandom, 0);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_leftover act=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
